regfile_wb_ctrl: RTL and testbench

Write-back controller that owns the register file's write port (`write`, `waddr1`, `din`). It accepts results from two pipeline producers, the load unit and the ALU, through valid/ready handshakes. It queues them in order in a small FIFO and retires at most one register write per cycle. It also provides combinational bypass lookups so the decode stage sees queued-but-unwritten values.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_fifo.sv | 61 ++++++
 rtl/regfile_wb_ctrl.sv | 97 +++++++++
 tb/tb_regfile_wb_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file write-back controller.
package wb_pkg;
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    localparam logic [WB_DATA_W-1:0] ZeroWord = '0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Dual-push / single-pop circular buffer; exposes storage so the owner can scan it.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wb_entry_t,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push0,
    input  T                     din0,
    input  logic                 push1,
    input  T                     din1,
    input  logic                 pop,
    output logic [CNT_W-1:0]     count,
    output logic [PTR_W-1:0]     head_ptr,
    output T                     head,
    output T [DEPTH-1:0]         mem
);
    T [DEPTH-1:0]     mem_q, mem_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // push1 is only ever asserted together with push0 and lands one slot behind it
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        if (push0) begin
            mem_d[tail_q] = din0;
            tail_d        = tail_q + PTR_W'(1);
        end
        if (push1) begin
            mem_d[tail_q + PTR_W'(1)] = din1;
            tail_d                    = tail_q + PTR_W'(2);
        end
        if (pop) head_d = head_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    assign count    = count_q;
    assign head_ptr = head_q;
    assign head     = mem_q[head_q];
    assign mem      = mem_q;
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: merges load and ALU results in order and owns the register-file write port.
module regfile_wb_ctrl
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    output logic              write,
    output logic [ADDR_W-1:0] waddr1,
    output logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data,
    output logic              wb_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   head_ptr;
    entry_t             head, din0, din1;
    entry_t [DEPTH-1:0] mem;
    logic               ld_acc, alu_acc, push0, push1, pop;

    // Readies look only at registered occupancy; ALU needs room for a same-cycle load too
    assign ld_ready  = rst && (count <= CNT_W'(DEPTH - 1));
    assign alu_ready = rst && (count <= CNT_W'(DEPTH - 2));
    assign ld_acc    = ld_valid  && ld_ready;
    assign alu_acc   = alu_valid && alu_ready;

    assign push0 = ld_acc || alu_acc;
    assign push1 = ld_acc && alu_acc;
    assign din0  = ld_acc ? entry_t'{ld_addr, ld_data} : entry_t'{alu_addr, alu_data};
    assign din1  = entry_t'{alu_addr, alu_data};
    assign pop   = (count != '0);

    wb_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push0    (push0),
        .din0     (din0),
        .push1    (push1),
        .din1     (din1),
        .pop      (pop),
        .count    (count),
        .head_ptr (head_ptr),
        .head     (head),
        .mem      (mem)
    );

    assign write    = pop;
    assign waddr1   = pop ? head.addr : '0;
    assign din      = pop ? head.data : DATA_W'(ZeroWord);
    assign wb_empty = !pop;

    // Scan oldest to youngest so the last match (youngest) wins
    logic [PTR_W-1:0] idx;
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = DATA_W'(ZeroWord);
        fwd2_data = DATA_W'(ZeroWord);
        idx       = head_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (mem[idx].addr == raddr1) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = mem[idx].data;
                end
                if (mem[idx].addr == raddr2) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = mem[idx].data;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed and random checks of regfile_wb_ctrl against a queue-based reference model.
module tb_regfile_wb_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, alu_valid;
    logic [4:0]  ld_addr, alu_addr, raddr1, raddr2, waddr1;
    logic [31:0] ld_data, alu_data, din, fwd1_data, fwd2_data;
    logic        ld_ready, alu_ready, write, fwd1_hit, fwd2_hit, wb_empty;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];

    int n_assert = 0;
    int n_fail   = 0;

    regfile_wb_ctrl dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .write(write), .waddr1(waddr1), .din(din),
        .raddr1(raddr1), .raddr2(raddr2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .wb_empty(wb_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output with what the model queue implies
    task automatic check_model();
        logic        eh1, eh2;
        logic [31:0] ed1, ed2;
        int          n;
        n = q.size();
        eh1 = 0; eh2 = 0; ed1 = 0; ed2 = 0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!eh1 && q[i].a == raddr1) begin eh1 = 1; ed1 = q[i].d; end
            if (!eh2 && q[i].a == raddr2) begin eh2 = 1; ed2 = q[i].d; end
        end
        chk("write",     32'(write),     32'(n != 0));
        chk("waddr1",    32'(waddr1),    n != 0 ? 32'(q[0].a) : 32'd0);
        chk("din",       din,            n != 0 ? q[0].d : 32'd0);
        chk("wb_empty",  32'(wb_empty),  32'(n == 0));
        chk("ld_ready",  32'(ld_ready),  32'(n <= 3));
        chk("alu_ready", 32'(alu_ready), 32'(n <= 2));
        chk("fwd1_hit",  32'(fwd1_hit),  32'(eh1));
        chk("fwd1_data", fwd1_data,      ed1);
        chk("fwd2_hit",  32'(fwd2_hit),  32'(eh2));
        chk("fwd2_data", fwd2_data,      ed2);
    endtask

    // One cycle: drive at negedge, check, clock, update the model
    task automatic step(input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic [4:0] r1, input logic [4:0] r2);
        logic lacc, aacc;
        ld_valid = lv; ld_addr = la; ld_data = ld;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        raddr1 = r1; raddr2 = r2;
        #1;
        check_model();
        lacc = lv && (q.size() <= 3);
        aacc = av && (q.size() <= 2);
        @(posedge clk);
        if (q.size() != 0) void'(q.pop_front());
        if (lacc) q.push_back('{la, ld});
        if (aacc) q.push_back('{aa, ad});
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] r1);
        step(0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    initial begin
        rst = 1'b0;
        ld_valid = 0; ld_addr = 0; ld_data = 0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        raddr1 = 0; raddr2 = 0;
        @(negedge clk);
        chk("rst_write",     32'(write),     32'd0);
        chk("rst_empty",     32'(wb_empty),  32'd1);
        chk("rst_ld_ready",  32'(ld_ready),  32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_fwd1_hit",  32'(fwd1_hit),  32'd0);
        rst = 1'b1;

        // single load latency
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        chk("lat_write", 32'(write), 32'd1);
        chk("lat_addr",  32'(waddr1), 32'd5);
        chk("lat_din",   din, 32'hDEADBEEF);
        idle(0);
        idle(0);

        // dual push ordering: load first
        step(1, 3, 32'h11, 1, 4, 32'h22, 3, 4);
        chk("ord0_addr", 32'(waddr1), 32'd3);
        idle(4);
        chk("ord1_addr", 32'(waddr1), 32'd4);
        chk("ord1_din",  din, 32'h22);
        idle(0);

        // fill to 3, ALU stalls while load still flows
        step(1, 1, 32'h101, 1, 2, 32'h102, 1, 2);
        step(1, 6, 32'h106, 1, 8, 32'h108, 6, 8);
        chk("fill_alu_ready", 32'(alu_ready), 32'd0);
        step(1, 9, 32'h109, 1, 10, 32'h10A, 9, 10);
        step(0, 0, 0, 1, 11, 32'h10B, 9, 11);
        step(0, 0, 0, 1, 11, 32'h10B, 9, 11);
        repeat (4) idle(0);

        // bypass youngest wins, clears after retire
        step(1, 7, 32'hA, 1, 7, 32'hB, 7, 7);
        chk("byp_hit",  32'(fwd1_hit), 32'd1);
        chk("byp_data", fwd1_data, 32'hB);
        idle(7);
        idle(7);
        chk("byp_clr_hit",  32'(fwd1_hit), 32'd0);
        chk("byp_clr_data", fwd1_data, 32'd0);

        // reset mid-traffic with 3 queued entries
        step(1, 12, 32'hC0, 1, 13, 32'hC1, 0, 0);
        step(1, 14, 32'hC2, 1, 15, 32'hC3, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_write",  32'(write),     32'd0);
        chk("mid_rst_empty",  32'(wb_empty),  32'd1);
        chk("mid_rst_ldrdy",  32'(ld_ready),  32'd0);
        chk("mid_rst_alurdy", 32'(alu_ready), 32'd0);
        q.delete();
        ld_valid = 0; alu_valid = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) idle(12);

        // random traffic against the model
        for (int c = 0; c < 1000; c++) begin
            step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        repeat (5) idle(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
